// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the SPI arbiter and its helpers
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} arb_state_t;
  localparam int DW_WIDTH = 6;
endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: bus between the arbiter and the shared spi_master
interface spi_arbiter_if
  import spi_pkg::*;
#(parameter int DATA_BITS = 8);
  logic spi_en;
  logic [DATA_BITS-1:0] data_in;
  logic [DW_WIDTH-1:0] data_words;
  logic ready_out;
  logic valid_out;
  logic [DATA_BITS-1:0] data_out;
  modport master (output spi_en, data_in, data_words, input ready_out, valid_out, data_out);
  modport slave (input spi_en, data_in, data_words, output ready_out, valid_out, data_out);
endinterface

// File: rtl/rr_select.sv
// rr_select: first set request at or after ptr, searched cyclically
module rr_select #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  sel_oh,
  output logic [IW-1:0] sel_idx
);
  logic [IW-1:0] j;
  // walk from farthest to nearest so the nearest hit wins
  always_comb begin
    sel_idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) sel_idx = j;
    end
  end
  assign sel_oh = |req ? N'(1) << sel_idx : '0;
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one spi_master among NUM_REQ burst requesters
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_BITS = 8,
  parameter int LEN_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*LEN_BITS-1:0]   req_len,
  input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            word_ack,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_BITS-1:0]          rsp_data,
  output logic                          busy,
  spi_arbiter_if.master                 bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state;
  logic [IW-1:0] ptr, sel, nxt_idx;
  logic [NUM_REQ-1:0] nxt_oh;
  logic [LEN_BITS-1:0] len, cnt;
  logic [LEN_BITS-1:0] nxt_len;
  rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
    .req(req),
    .ptr(ptr),
    .sel_oh(nxt_oh),
    .sel_idx(nxt_idx)
  );
  assign nxt_len = req_len[nxt_idx*LEN_BITS +: LEN_BITS];
  assign bus.spi_en = state == ISSUE;
  assign busy = state != IDLE;
  // ack in the transfer cycle so the requester's next word is ready before WAIT reloads it
  assign word_ack = (state == ISSUE && bus.ready_out) ? gnt : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      gnt <= '0;
      len <= '0;
      cnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      bus.data_in <= '0;
      bus.data_words <= '0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: if (|req) begin
          gnt <= nxt_oh;
          sel <= nxt_idx;
          len <= nxt_len;
          cnt <= '0;
          bus.data_in <= req_data[nxt_idx*DATA_BITS +: DATA_BITS];
          bus.data_words <= DW_WIDTH'(nxt_len) + DW_WIDTH'(1);
          state <= ISSUE;
        end
        ISSUE: if (bus.ready_out) state <= WAIT;
        WAIT: if (bus.valid_out) begin
          rsp_data <= bus.data_out;
          rsp_valid <= gnt;
          if (cnt == len) state <= RELEASE;
          else begin
            cnt <= cnt + LEN_BITS'(1);
            bus.data_in <= req_data[sel*DATA_BITS +: DATA_BITS];
            state <= ISSUE;
          end
        end
        RELEASE: begin
          gnt <= '0;
          ptr <= (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed checks of grant order, burst flow, reset abort and stray responses
module tb_spi_arbiter;
  logic clk = 0;
  logic reset;
  logic [3:0] req;
  logic [7:0] req_len;
  logic [31:0] req_data;
  logic [3:0] gnt, word_ack, rsp_valid;
  logic [7:0] rsp_data;
  logic busy;
  int n_vec = 0;
  int n_err = 0;
  spi_arbiter_if #(.DATA_BITS(8)) bus ();
  spi_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .LEN_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_len(req_len),
    .req_data(req_data),
    .gnt(gnt),
    .word_ack(word_ack),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .busy(busy),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_issue();
    int k = 0;
    while (!bus.spi_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("issue_timeout", 32'(k < 20), 1);
  endtask
  // one word: grant check, handshake, echo, response check; nxt is the requester's next TX word
  task automatic xfer(input logic [3:0] g, input logic [7:0] din, input logic [5:0] dw,
                      input logic [7:0] echo, input int r, input logic [7:0] nxt);
    wait_issue();
    chk("gnt", gnt, g);
    chk("gnt_onehot", 32'($onehot0(gnt)), 1);
    chk("data_in", bus.data_in, din);
    chk("data_words", bus.data_words, dw);
    bus.ready_out = 1;
    #1 chk("word_ack", word_ack, g);
    req_data[r*8 +: 8] = nxt;
    @(negedge clk);
    bus.ready_out = 0;
    chk("spi_en_wait", bus.spi_en, 0);
    bus.valid_out = 1;
    bus.data_out = echo;
    @(negedge clk);
    bus.valid_out = 0;
    chk("rsp_valid", rsp_valid, g);
    chk("rsp_data", rsp_data, echo);
  endtask
  initial begin
    reset = 1;
    req = 0;
    req_len = 0;
    req_data = 0;
    bus.ready_out = 0;
    bus.valid_out = 0;
    bus.data_out = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spi_en", bus.spi_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_data_words", bus.data_words, 0);
    reset = 0;
    // single requester, one word
    req = 4'b0100;
    req_data[23:16] = 8'hA5;
    @(negedge clk);
    chk("t1_grant_latency", gnt, 4'b0100);
    xfer(4'b0100, 8'hA5, 6'd1, 8'h3C, 2, 8'hA5);
    chk("t1_busy_release", busy, 1);
    req = 0;
    @(negedge clk);
    chk("t1_gnt_drop", gnt, 0);
    chk("t1_idle", busy, 0);
    chk("t1_no_rsp", rsp_valid, 0);
    // four-word burst on requester 0, req dropped mid-burst
    req = 4'b0001;
    req_len[1:0] = 2'd3;
    req_data[7:0] = 8'h11;
    xfer(4'b0001, 8'h11, 6'd4, 8'hC1, 0, 8'h22);
    req = 0;
    xfer(4'b0001, 8'h22, 6'd4, 8'hC2, 0, 8'h33);
    xfer(4'b0001, 8'h33, 6'd4, 8'hC3, 0, 8'h44);
    xfer(4'b0001, 8'h44, 6'd4, 8'hC4, 0, 8'h44);
    @(negedge clk);
    chk("t2_idle", busy, 0);
    // contention from reset
    reset = 1;
    @(negedge clk);
    reset = 0;
    req_len = 0;
    req_data = 32'h40302010;
    req = 4'b1111;
    xfer(4'b0001, 8'h10, 6'd1, 8'h50, 0, 8'h10);
    xfer(4'b0010, 8'h20, 6'd1, 8'h51, 1, 8'h20);
    xfer(4'b0100, 8'h30, 6'd1, 8'h52, 2, 8'h30);
    xfer(4'b1000, 8'h40, 6'd1, 8'h53, 3, 8'h40);
    xfer(4'b0001, 8'h10, 6'd1, 8'h54, 0, 8'h10);
    req = 0;
    // wrap and fairness: last grant to 3, then 1 and 3 held
    req = 4'b1000;
    xfer(4'b1000, 8'h40, 6'd1, 8'h60, 3, 8'h40);
    req = 4'b1010;
    xfer(4'b0010, 8'h20, 6'd1, 8'h61, 1, 8'h20);
    xfer(4'b1000, 8'h40, 6'd1, 8'h62, 3, 8'h40);
    xfer(4'b0010, 8'h20, 6'd1, 8'h63, 1, 8'h20);
    xfer(4'b1000, 8'h40, 6'd1, 8'h64, 3, 8'h40);
    req = 0;
    // reset in WAIT of word 2
    req = 4'b0001;
    req_len[1:0] = 2'd3;
    req_data[7:0] = 8'h51;
    xfer(4'b0001, 8'h51, 6'd4, 8'h70, 0, 8'h52);
    wait_issue();
    chk("t5_data_in2", bus.data_in, 8'h52);
    bus.ready_out = 1;
    @(negedge clk);
    bus.ready_out = 0;
    reset = 1;
    req = 0;
    bus.valid_out = 1;
    bus.data_out = 8'h77;
    @(negedge clk);
    reset = 0;
    bus.valid_out = 0;
    chk("t5_gnt", gnt, 0);
    chk("t5_spi_en", bus.spi_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("t5_no_rsp_late", rsp_valid, 0);
    req_len = 0;
    req = 4'b1111;
    xfer(4'b0001, 8'h52, 6'd1, 8'h71, 0, 8'h52);
    req = 0;
    @(negedge clk);
    // stray valid_out in IDLE
    chk("t6_idle", busy, 0);
    bus.valid_out = 1;
    bus.data_out = 8'hFF;
    @(negedge clk);
    bus.valid_out = 0;
    chk("t6_no_rsp", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_gnt", gnt, 0);
    @(negedge clk);
    chk("t6_no_rsp_late", rsp_valid, 0);
    chk("t6_rsp_data", rsp_data, 8'h71);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares the single SPI master instance between NUM_REQ requesters, e.g. the word-burst sequencer plus configuration and status pollers.
- Each requester asks for a burst of 1..2^LEN_BITS words. The arbiter grants requesters round-robin and drives the master's spi_en, data_in and data_words.
- Each received word goes back to the owning requester.
- The arbiter sits between the requester logic and spi_master, in place of a dedicated per-user controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_BITS, 8, SPI word width; must match spi_master.
- LEN_BITS, 2, burst-length field width; the burst is req_len+1 words.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request level
- req_len  in  NUM_REQ*LEN_BITS  per-requester burst length minus 1; slice i belongs to requester i
- req_data  in  NUM_REQ*DATA_BITS  per-requester current TX word; slice i
- gnt  out  NUM_REQ  one-hot grant; held for the whole burst
- word_ack  out  NUM_REQ  1-cycle pulse when the granted requester's current word is taken by the master
- rsp_valid  out  NUM_REQ  1-cycle pulse, received word for requester i
- rsp_data  out  DATA_BITS  received word; valid with rsp_valid
- busy  out  1  high whenever the state is not IDLE
- spi_en  out  1  to spi_master
- data_in  out  DATA_BITS  to spi_master
- data_words  out  6  to spi_master; equals req_len+1 of the granted requester
- ready_out  in  1  from spi_master
- valid_out  in  1  from spi_master
- data_out  in  DATA_BITS  from spi_master

Behaviour:
- Reset
  - One clock, synchronous active-high reset.
  - All outputs go to 0; state goes to IDLE; round-robin pointer goes to 0; word counter goes to 0.
  - Reset mid-burst aborts the burst: gnt and spi_en drop on the next edge and no rsp_valid is emitted.
- Master contract
  - A word transfers on a cycle where spi_en && ready_out.
  - valid_out pulses once per transferred word, with data_out valid.
- States
  - IDLE:
    - If any req bit is set, select the first set bit at or after ptr, searching cyclically.
    - Register gnt, data_in = req_data[sel], data_words = req_len[sel]+1, cnt = 0.
    - Go to ISSUE. Grant latency is 1 cycle.
  - ISSUE:
    - spi_en = 1.
    - On ready_out: pulse word_ack[sel], drop spi_en, go to WAIT.
  - WAIT:
    - On valid_out: rsp_data = data_out and pulse rsp_valid[sel] next cycle (registered).
    - If cnt == len: go to RELEASE.
    - Otherwise: cnt += 1, data_in = req_data[sel] (requester has updated it after word_ack), go to ISSUE.
  - RELEASE:
    - gnt = 0, ptr = (sel+1) mod NUM_REQ, go to IDLE.
    - Minimum gap between bursts is 1 cycle.
- req, req_len and req_data slices are sampled only at the points above. len is latched at grant. req deassertion mid-burst is ignored; the burst always completes.
- valid_out in IDLE, ISSUE or RELEASE is ignored (stray): no rsp_valid.
- valid_out and ready_out in the same cycle act only per the current state.
- Pointer wrap: ptr = NUM_REQ-1 searches NUM_REQ-1, 0, 1, …
- Simultaneous requests with ptr = 0 grant index 0 first.
- A requester holding req continuously is re-granted only after every other pending requester has been served once.
- Invariant: gnt is one-hot or zero; gnt == 0 exactly when in IDLE.

Decomposition:
- Shared package spi_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RELEASE);
  - localparam DW_WIDTH = 6 for data_words.
- Sub-module rr_select (combinational): req vector + ptr -> one-hot select + index.
  - It is reusable by other SPI schedulers.

Test Plan:
- Single requester: req[2]=1, req_len[2]=0, req_data[2]=8'hA5; master echoes 8'h3C.
  - Expected: gnt=4'b0100 one cycle after req, data_words=1, one word_ack[2], one rsp_valid[2] with rsp_data=8'h3C, then gnt=0.
- Burst of 4: req[0], len=3, words 8'h11/22/33/44 updated on each word_ack.
  - Expected: data_in sequence 11, 22, 33, 44; four rsp_valid[0] pulses in order; data_words=4 for the whole burst.
- Contention: req=4'b1111 held, each len=0, from reset.
  - Expected: grant order 0, 1, 2, 3, 0; no two gnt bits ever high together.
- Wrap and fairness: req[3] and req[1] held after the last grant went to 3.
  - Expected: next grants are 1, then 3, alternating.
- Reset mid-burst: assert reset in WAIT of word 2 of a 4-word burst.
  - Expected: next cycle gnt=0, spi_en=0, busy=0, no further rsp_valid; a new req is granted normally with ptr=0.
- Stray valid_out in IDLE with data_out=8'hFF.
  - Expected: no rsp_valid, state stays IDLE.
